// File: rtl/query_pingpong_ctrl.sv
// rtl/query_pingpong_ctrl.sv - ping-pong sequencer for two query row buffers
// Define QPP_PERF_EN to add saturating fill-stall / read-starve counters.
module query_pingpong_ctrl #(
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 128,
  parameter int ROW_LEN    = 128,
  parameter int ROW_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ROW_CNT_W-1:0]  num_rows,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [1:0]            fill_en,
  output logic [1:0]            ren,
  output logic [ADDR_WIDTH-1:0] radr,
  input  logic                  out_ready,
  output logic                  rd_valid,
  output logic                  rd_bank,
  output logic                  row_last,
  output logic [1:0]            buf_clr_n,
  output logic                  busy,
`ifdef QPP_PERF_EN
  output logic [15:0]           fill_stall_cnt,
  output logic [15:0]           read_starve_cnt,
`endif
  output logic                  done
);

  // A row never spans more entries than the buffer holds.
  localparam int ROW_WORDS = (ROW_LEN < DEPTH) ? ROW_LEN : DEPTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(ROW_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ROW_CNT_W-1:0]  ROW_ONE  = ROW_CNT_W'(1);

  typedef enum logic {ST_IDLE, ST_RUN} top_e;
  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_READING} bank_e;

  top_e                  st_q, st_d;
  bank_e                 bank_q [2];
  bank_e                 bank_d [2];
  logic                  fill_ptr_q, fill_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic [ROW_CNT_W-1:0]  num_rows_q, num_rows_d;
  logic [ROW_CNT_W-1:0]  rows_filled_q, rows_filled_d, rows_read_q, rows_read_d;
  logic                  rd_valid_q, rd_valid_d, rd_bank_q, rd_bank_d;
  logic                  row_last_q, row_last_d;
  logic [1:0]            buf_clr_q, buf_clr_d;
  logic                  done_q, done_d;

  logic run, can_fill, can_read, wr_acc, rd_go, wr_last, rd_last;

  always_comb begin
    run      = (st_q == ST_RUN);
    can_fill = (bank_q[fill_ptr_q] == B_EMPTY) || (bank_q[fill_ptr_q] == B_FILLING);
    can_read = (bank_q[rd_ptr_q] == B_FULL) || (bank_q[rd_ptr_q] == B_READING);
    // A bank in its clear cycle must not take the first write of its next row.
    in_ready = run && can_fill && (rows_filled_q < num_rows_q) && buf_clr_q[fill_ptr_q];
    wr_acc   = in_valid && in_ready;
    rd_go    = run && out_ready && can_read;
    wr_last  = wr_acc && (wcnt_q == LAST_IDX);
    rd_last  = rd_go && (rcnt_q == LAST_IDX);
    fill_en  = in_ready ? (fill_ptr_q ? 2'b10 : 2'b01) : 2'b00;
    ren      = rd_go ? (rd_ptr_q ? 2'b10 : 2'b01) : 2'b00;
  end

  always_comb begin
    st_d          = st_q;
    bank_d        = bank_q;
    fill_ptr_d    = fill_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    wcnt_d        = wcnt_q;
    rcnt_d        = rcnt_q;
    num_rows_d    = num_rows_q;
    rows_filled_d = rows_filled_q;
    rows_read_d   = rows_read_q;
    rd_valid_d    = rd_go;
    rd_bank_d     = rd_ptr_q;
    row_last_d    = rd_last;
    buf_clr_d     = 2'b11;
    done_d        = 1'b0;

    if (wr_acc) begin
      wcnt_d             = wr_last ? '0 : wcnt_q + ADR_ONE;
      bank_d[fill_ptr_q] = wr_last ? B_FULL : B_FILLING;
      if (wr_last) begin
        fill_ptr_d = ~fill_ptr_q;
        if (rows_filled_q != num_rows_q) rows_filled_d = rows_filled_q + ROW_ONE;
      end
    end

    if (rd_go) begin
      rcnt_d           = rd_last ? '0 : rcnt_q + ADR_ONE;
      bank_d[rd_ptr_q] = rd_last ? B_EMPTY : B_READING;
      if (rd_last) begin
        rd_ptr_d            = ~rd_ptr_q;
        buf_clr_d[rd_ptr_q] = 1'b0;
        if (rows_read_q != num_rows_q) rows_read_d = rows_read_q + ROW_ONE;
      end
    end

    case (st_q)
      ST_IDLE: begin
        if (start) begin
          num_rows_d    = num_rows;
          fill_ptr_d    = 1'b0;
          rd_ptr_d      = 1'b0;
          wcnt_d        = '0;
          rcnt_d        = '0;
          rows_filled_d = '0;
          rows_read_d   = '0;
          bank_d[0]     = B_EMPTY;
          bank_d[1]     = B_EMPTY;
          if (num_rows == '0) done_d = 1'b1;
          else                st_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        // Finish once the final word of the final row has been handed over.
        if (rd_valid_q && row_last_q && (rows_read_q == num_rows_q)) begin
          st_d   = ST_IDLE;
          done_d = 1'b1;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q          <= ST_IDLE;
      bank_q[0]     <= B_EMPTY;
      bank_q[1]     <= B_EMPTY;
      fill_ptr_q    <= 1'b0;
      rd_ptr_q      <= 1'b0;
      wcnt_q        <= '0;
      rcnt_q        <= '0;
      num_rows_q    <= '0;
      rows_filled_q <= '0;
      rows_read_q   <= '0;
      rd_valid_q    <= 1'b0;
      rd_bank_q     <= 1'b0;
      row_last_q    <= 1'b0;
      buf_clr_q     <= 2'b00;
      done_q        <= 1'b0;
    end else begin
      st_q          <= st_d;
      bank_q[0]     <= bank_d[0];
      bank_q[1]     <= bank_d[1];
      fill_ptr_q    <= fill_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      wcnt_q        <= wcnt_d;
      rcnt_q        <= rcnt_d;
      num_rows_q    <= num_rows_d;
      rows_filled_q <= rows_filled_d;
      rows_read_q   <= rows_read_d;
      rd_valid_q    <= rd_valid_d;
      rd_bank_q     <= rd_bank_d;
      row_last_q    <= row_last_d;
      buf_clr_q     <= buf_clr_d;
      done_q        <= done_d;
    end
  end

  assign radr      = rcnt_q;
  assign rd_valid  = rd_valid_q;
  assign rd_bank   = rd_bank_q;
  assign row_last  = row_last_q;
  assign buf_clr_n = buf_clr_q;
  assign busy      = run;
  assign done      = done_q;

`ifdef QPP_PERF_EN
  logic [15:0] fill_stall_q, fill_stall_d, read_starve_q, read_starve_d;

  always_comb begin
    fill_stall_d  = fill_stall_q;
    read_starve_d = read_starve_q;
    if ((st_q == ST_IDLE) && start) begin
      fill_stall_d  = '0;
      read_starve_d = '0;
    end else begin
      if (run && in_valid && !in_ready && (fill_stall_q != 16'hFFFF))
        fill_stall_d = fill_stall_q + 16'd1;
      if (run && out_ready && !can_read && (read_starve_q != 16'hFFFF))
        read_starve_d = read_starve_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_stall_q  <= '0;
      read_starve_q <= '0;
    end else begin
      fill_stall_q  <= fill_stall_d;
      read_starve_q <= read_starve_d;
    end
  end

  assign fill_stall_cnt  = fill_stall_q;
  assign read_starve_cnt = read_starve_q;
`endif

endmodule
